// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with programmable limit, wrap or saturate policy,
// a registered terminal-count pulse and sticky overflow/underflow flags.
module updown_mod_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             up,
  input  logic [WIDTH-1:0] limit,
  input  logic             saturate,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO    = '0;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             unf_q;
  logic             unf_d;
  logic             ovf_set;
  logic             unf_set;

  logic             step;
  logic             at_hi;
  logic             above;
  logic             at_zero;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] load_val;

  assign step     = enable & ~load;
  assign at_hi    = count_q >= limit;
  assign above    = count_q > limit;
  assign at_zero  = count_q == ZERO;
  assign inc      = count_q + ONE;
  assign dec      = count_q - ONE;
  assign load_val = (data > limit) ? limit : data;

  // The step cases are mutually exclusive: load wins, then direction,
  // then the position of count relative to 0 and limit.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (1'b1)
      load: begin
        count_d = load_val;
      end
      step && up && !at_hi: begin
        count_d = inc;
        tc_d    = saturate && (inc == limit);
      end
      step && up && at_hi: begin
        count_d = saturate ? limit : ZERO;
        tc_d    = ~saturate;
        ovf_set = 1'b1;
      end
      step && !up && above: begin
        count_d = limit;
      end
      step && !up && at_zero: begin
        count_d = saturate ? ZERO : limit;
        tc_d    = ~saturate;
        unf_set = 1'b1;
      end
      step && !up && !above && !at_zero: begin
        count_d = dec;
        tc_d    = saturate && (dec == ZERO);
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // A set event in the same cycle as clr_flags leaves the flag set.
  assign ovf_d = ovf_set | (ovf_q & ~clr_flags);
  assign unf_d = unf_set | (unf_q & ~clr_flags);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      count_q <= RST_CNT;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter: directed steps push expected
// results, a monitor pops and compares one entry after each rising edge.
module tb_updown_mod_counter;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] cnt;
    logic         tc;
    logic         ovf;
    logic         unf;
    string        name;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_ = 1'b0;
  logic         enable = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] data = '0;
  logic         up = 1'b1;
  logic [W-1:0] limit = '0;
  logic         saturate = 1'b0;
  logic         clr_flags = 1'b0;
  logic [W-1:0] count;
  logic         tc;
  logic         ovf;
  logic         unf;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  updown_mod_counter #(.WIDTH(W), .RESET_VAL(0)) dut (
    .clk(clk), .rst_(rst_), .enable(enable), .load(load),
    .data(data), .up(up), .limit(limit), .saturate(saturate),
    .clr_flags(clr_flags), .count(count), .tc(tc), .ovf(ovf),
    .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W+2:0] act,
                       input logic [W+2:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got cnt=%0d tc=%b ovf=%b unf=%b want cnt=%0d tc=%b ovf=%b unf=%b",
               name, act[W+2:3], act[2], act[1], act[0],
               req[W+2:3], req[2], req[1], req[0]);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, {count, tc, ovf, unf}, {e.cnt, e.tc, e.ovf, e.unf});
    end
  end

  task automatic step(input string name, input logic en, input logic ld,
                      input int d, input logic u, input int lim,
                      input logic sat, input logic clr, input int ecnt,
                      input logic etc, input logic eovf, input logic eunf);
    exp_t e;
    @(negedge clk);
    enable = en; load = ld; data = W'(d); up = u;
    limit = W'(lim); saturate = sat; clr_flags = clr;
    e.cnt = W'(ecnt); e.tc = etc; e.ovf = eovf; e.unf = eunf;
    e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    #2;
    check("reset_init", {count, tc, ovf, unf}, '0);
    @(negedge clk);
    rst_ = 1'b1;

    // Reset mid-count
    step("load17", 0, 1, 17, 1, 100, 0, 0, 17, 0, 0, 0);
    @(posedge clk);
    #3;
    rst_ = 1'b0;
    #1;
    check("async_reset", {count, tc, ovf, unf}, '0);
    @(negedge clk);
    enable = 0; load = 0;
    rst_ = 1'b1;

    // Wrap up, limit 9
    for (int i = 1; i <= 12; i++) begin
      int c;
      c = i % 10;
      step($sformatf("wrap_up_%0d", i), 1, 0, 0, 1, 9, 0, 0,
           c, (i == 10), (i >= 10), 0);
    end

    // Saturating down from 3
    step("clr_a", 0, 0, 0, 1, 9, 0, 1, 2, 0, 0, 0);
    step("load3", 0, 1, 3, 0, 9, 1, 0, 3, 0, 0, 0);
    step("sat_dn_1", 1, 0, 0, 0, 9, 1, 0, 2, 0, 0, 0);
    step("sat_dn_2", 1, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0);
    step("sat_dn_3", 1, 0, 0, 0, 9, 1, 0, 0, 1, 0, 0);
    step("sat_dn_4", 1, 0, 0, 0, 9, 1, 0, 0, 0, 0, 1);
    step("sat_dn_5", 1, 0, 0, 0, 9, 1, 0, 0, 0, 0, 1);

    // Load priority and clamp
    step("load_clamp", 1, 1, 200, 1, 50, 0, 0, 50, 0, 0, 1);
    step("load20", 0, 1, 20, 1, 50, 0, 0, 20, 0, 0, 1);
    step("clr_b", 0, 0, 0, 1, 50, 0, 1, 20, 0, 0, 0);

    // Dynamic limit
    step("load40_a", 0, 1, 40, 1, 60, 0, 0, 40, 0, 0, 0);
    step("dyn_wrap", 1, 0, 0, 1, 30, 0, 0, 0, 1, 1, 0);
    step("load40_b", 0, 1, 40, 1, 60, 0, 0, 40, 0, 1, 0);
    step("dyn_sat", 1, 0, 0, 1, 30, 1, 0, 30, 0, 1, 0);

    // Flag clear and clear/set race
    step("clr_ovf", 0, 0, 0, 1, 30, 0, 1, 30, 0, 0, 0);
    step("clr_race", 1, 0, 0, 1, 30, 0, 1, 0, 1, 1, 0);
    step("hold_after", 0, 0, 0, 1, 30, 0, 0, 0, 0, 1, 0);
    step("clr_c", 0, 0, 0, 1, 30, 0, 1, 0, 0, 0, 0);

    // limit = 0 wrap down: tc on consecutive cycles
    step("lim0_dn_1", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step("lim0_dn_2", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step("lim0_up", 1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1);
    step("clr_d", 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);

    // Saturating up arrival, then down resync
    step("load7", 0, 1, 7, 1, 9, 1, 0, 7, 0, 0, 0);
    step("sat_up_1", 1, 0, 0, 1, 9, 1, 0, 8, 0, 0, 0);
    step("sat_up_2", 1, 0, 0, 1, 9, 1, 0, 9, 1, 0, 0);
    step("sat_up_3", 1, 0, 0, 1, 9, 1, 0, 9, 0, 1, 0);
    step("resync_dn", 1, 0, 0, 0, 5, 0, 0, 5, 0, 1, 0);
    step("wrap_dn", 1, 0, 0, 0, 5, 0, 0, 4, 0, 1, 0);

    @(negedge clk);
    enable = 0; load = 0; clr_flags = 0;
    for (int n = 0; n < 20 && sb.size() > 0; n++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
